// File: rtl/serializador_entrada.sv
// serializador_entrada: parallel-to-serial stage with a one-deep input buffer,
// feeding the serial input of a downstream shift register.
module serializador_entrada #(
   parameter int LARGURA      = 4,
   parameter int MSB_PRIMEIRO = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] dado,
   input  logic               dado_valido,
   output logic               dado_pronto,
   output logic               saida,
   output logic               saida_valida,
   output logic               fim_palavra,
   output logic               ocupado
);
   localparam int IW = $clog2(LARGURA);
   localparam logic [IW-1:0] ULTIMO = IW'(LARGURA - 1);

   typedef enum logic {OCIOSO, DESLOCA} estado_t;

   estado_t            estado, estado_prox;
   logic [IW-1:0]      idx, idx_prox;
   logic [LARGURA-1:0] shift, shift_prox, buffer, buffer_prox, deslocado;
   logic               buffer_cheio, buffer_cheio_prox;
   logic               transfer, ultimo_bit;

   assign dado_pronto = !buffer_cheio && !reset;
   assign transfer    = dado_valido && dado_pronto;
   assign ultimo_bit  = (estado == DESLOCA) && (idx == ULTIMO);
   assign deslocado   = (MSB_PRIMEIRO != 0) ? {shift[LARGURA-2:0], 1'b0}
                                            : {1'b0, shift[LARGURA-1:1]};

   always_ff @(posedge clock) begin
      if (reset) begin
         estado       <= OCIOSO;
         idx          <= '0;
         shift        <= '0;
         buffer       <= '0;
         buffer_cheio <= 1'b0;
      end else begin
         estado       <= estado_prox;
         idx          <= idx_prox;
         shift        <= shift_prox;
         buffer       <= buffer_prox;
         buffer_cheio <= buffer_cheio_prox;
      end
   end

   // On the last-bit edge a buffered word wins; dado_pronto was low then, so no transfer can collide.
   always_comb begin
      estado_prox       = estado;
      idx_prox          = idx;
      shift_prox        = shift;
      buffer_prox       = buffer;
      buffer_cheio_prox = buffer_cheio;
      if (estado == OCIOSO) begin
         if (transfer) begin
            estado_prox = DESLOCA;
            shift_prox  = dado;
            idx_prox    = '0;
         end
      end else if (!ultimo_bit) begin
         shift_prox = deslocado;
         idx_prox   = idx + 1'b1;
         if (transfer) begin
            buffer_prox       = dado;
            buffer_cheio_prox = 1'b1;
         end
      end else if (buffer_cheio) begin
         shift_prox        = buffer;
         buffer_cheio_prox = 1'b0;
         idx_prox          = '0;
      end else if (transfer) begin
         shift_prox = dado;
         idx_prox   = '0;
      end else begin
         estado_prox = OCIOSO;
      end
   end

   assign saida_valida = (estado == DESLOCA);
   assign fim_palavra  = ultimo_bit;
   assign ocupado      = (estado == DESLOCA) || buffer_cheio;
   assign saida        = saida_valida && ((MSB_PRIMEIRO != 0) ? shift[LARGURA-1] : shift[0]);

endmodule

// File: tb/tb_serializador_entrada.sv
// tb_serializador_entrada: MSB-first and LSB-first instances on shared stimulus,
// checked against a word-queue reference model and a downstream 4-bit shift register.
module tb_serializador_entrada;
   localparam int L = 4;

   logic         clock = 1'b0;
   logic         reset, dado_valido;
   logic [L-1:0] dado;
   logic         pronto_m, saida_m, valida_m, fim_m, ocupado_m;
   logic         pronto_l, saida_l, valida_l, fim_l, ocupado_l;
   logic [L-1:0] sr_m, sr_l;

   int           total = 0, bad = 0;
   logic [L-1:0] fila[$];
   int           pos = 0;
   logic [L-1:0] completa;
   logic         tem_completa = 1'b0;
   logic [L-1:0] palavras[$];

   always #5 clock = ~clock;

   serializador_entrada #(.LARGURA(L), .MSB_PRIMEIRO(1)) dut_m (
      .clock(clock), .reset(reset), .dado(dado), .dado_valido(dado_valido),
      .dado_pronto(pronto_m), .saida(saida_m), .saida_valida(valida_m),
      .fim_palavra(fim_m), .ocupado(ocupado_m));

   serializador_entrada #(.LARGURA(L), .MSB_PRIMEIRO(0)) dut_l (
      .clock(clock), .reset(reset), .dado(dado), .dado_valido(dado_valido),
      .dado_pronto(pronto_l), .saida(saida_l), .saida_valida(valida_l),
      .fim_palavra(fim_l), .ocupado(ocupado_l));

   // Downstream shift registers: MSB-first fills from the right, LSB-first from the left.
   always_ff @(posedge clock) begin
      sr_m <= {sr_m[L-2:0], saida_m};
      sr_l <= {saida_l, sr_l[L-1:1]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check against the model, advance the model at the edge.
   task automatic ciclo(input logic r, input logic v, input logic [L-1:0] d, output logic ac);
      logic         pronto, ativo;
      logic [L-1:0] cab;
      reset = r;
      dado_valido = v;
      dado = d;
      #1;
      ativo  = fila.size() > 0;
      pronto = (fila.size() < 2) && !r;
      cab    = ativo ? fila[0] : '0;
      check("pronto_m",  32'(pronto_m),  32'(pronto));
      check("pronto_l",  32'(pronto_l),  32'(pronto));
      check("valida_m",  32'(valida_m),  32'(ativo));
      check("valida_l",  32'(valida_l),  32'(ativo));
      check("saida_m",   32'(saida_m),   32'(ativo && cab[L-1-pos]));
      check("saida_l",   32'(saida_l),   32'(ativo && cab[pos]));
      check("fim_m",     32'(fim_m),     32'(ativo && pos == L-1));
      check("fim_l",     32'(fim_l),     32'(ativo && pos == L-1));
      check("ocupado_m", 32'(ocupado_m), 32'(ativo));
      check("ocupado_l", 32'(ocupado_l), 32'(ativo));
      if (tem_completa) begin
         check("reg_msb", 32'(sr_m), 32'(completa));
         check("reg_lsb", 32'(sr_l), 32'(completa));
         tem_completa = 1'b0;
      end
      ac = v && pronto;
      @(posedge clock);
      if (r) begin
         fila.delete();
         pos = 0;
      end else begin
         if (ativo) begin
            if (pos == L-1) begin
               completa = fila.pop_front();
               tem_completa = 1'b1;
               pos = 0;
            end else pos++;
         end
         if (ac) fila.push_back(d);
      end
      @(negedge clock);
   endtask

   task automatic ocioso(input int n);
      logic ac;
      for (int i = 0; i < n; i++) ciclo(1'b0, 1'b0, '0, ac);
   endtask

   // Holds dado_valido high, advancing to the next word only once accepted.
   task automatic fluxo();
      logic ac;
      int   k = 0;
      for (int n = 0; n < 10 * L * palavras.size() && k < palavras.size(); n++) begin
         ciclo(1'b0, 1'b1, palavras[k], ac);
         if (ac) k++;
      end
      check("aceitas", 32'(k), 32'(palavras.size()));
   endtask

   initial begin
      logic ac;
      reset = 1'b1;
      dado_valido = 1'b0;
      dado = '0;
      @(posedge clock);
      @(negedge clock);
      ciclo(1'b1, 1'b0, '0, ac);
      ocioso(2);
      // single word
      ciclo(1'b0, 1'b1, 4'b1011, ac);
      ocioso(6);
      // back-to-back under backpressure
      palavras = '{4'b1011, 4'b0110, 4'b1111};
      fluxo();
      ocioso(L + 3);
      // chained with the downstream register
      palavras = '{4'b1001, 4'b0011};
      fluxo();
      ocioso(L + 3);
      // reset mid-word with a buffered word
      ciclo(1'b0, 1'b1, 4'b1100, ac);
      ciclo(1'b0, 1'b1, 4'b0101, ac);
      ciclo(1'b0, 1'b0, '0, ac);
      ciclo(1'b1, 1'b0, '0, ac);
      ciclo(1'b0, 1'b1, 4'b0001, ac);
      ocioso(6);
      // transfer landing on the last-bit edge with an empty buffer
      ciclo(1'b0, 1'b1, 4'b1011, ac);
      ocioso(L - 1);
      ciclo(1'b0, 1'b1, 4'b0110, ac);
      ocioso(6);
      // randomized traffic with occasional reset
      for (int i = 0; i < 2000; i++)
         ciclo($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, L'($urandom), ac);
      ocioso(L + 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serializador_entrada.md
# serializador_entrada

Parallel-to-serial stage that feeds the serial `entrada` input of the 4-bit shift register. It accepts parallel words through a valid/ready handshake, holds at most one pending word in a one-deep buffer, and shifts each word out one bit per clock. A bit-valid strobe and an end-of-word strobe let the downstream register and any checker know when its outputs hold a complete word. Back-to-back words stream with no idle cycle between them.

## Interface
- `LARGURA`, default 4: word width in bits; legal range 2..16.
- `MSB_PRIMEIRO`, default 1: 1 sends the MSB first; 0 sends the LSB first.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dado`  in  LARGURA  parallel word to serialize.
- `dado_valido`  in  1  `dado` is valid this cycle.
- `dado_pronto`  out  1  block can accept a word this cycle.
- `saida`  out  1  serial bit; connects to the shift register's `entrada`.
- `saida_valida`  out  1  `saida` carries a data bit this cycle.
- `fim_palavra`  out  1  high during the last bit of each word.
- `ocupado`  out  1  a word is being shifted or a word is buffered.

## Operation
- Handshake:
  - A transfer occurs on an edge where `dado_valido && dado_pronto`.
  - `dado_pronto = !buffer_cheio && !reset`.
  - `dado` is sampled only on a transfer edge.
  - Upstream may drop `dado_valido` at any time without penalty.
- FSM states:
  - OCIOSO: nothing shifting.
  - DESLOCA: shift register active, bit counter `idx` runs 0..LARGURA-1.
- OCIOSO transitions:
  - On a transfer: load `dado` into the shift register, set `idx=0`, go to DESLOCA.
  - While in OCIOSO the buffer is always empty.
- DESLOCA, `idx < LARGURA-1`:
  - Each edge shifts one position and increments `idx`.
  - A transfer on this edge writes the one-deep buffer and sets `buffer_cheio`.
- DESLOCA, `idx == LARGURA-1` (last-bit edge), by priority:
  - (a) Buffer full: move the buffer into the shift register, clear `buffer_cheio`, `idx=0`, stay in DESLOCA.
  - (b) Buffer empty and a transfer this edge: load `dado` directly, `idx=0`, stay in DESLOCA.
  - (c) Otherwise: go to OCIOSO.
- In case (a), `dado_pronto` was 0 that cycle, so no transfer can coincide with it.
- Output bit:
  - `MSB_PRIMEIRO=1`: `saida = shift[LARGURA-1]`, shift left.
  - `MSB_PRIMEIRO=0`: `saida = shift[0]`, shift right.
- Output strobes:
  - `saida = 0` whenever `saida_valida = 0`.
  - `saida_valida = (estado == DESLOCA)`.
  - `fim_palavra = (estado == DESLOCA) && (idx == LARGURA-1)`.
  - `ocupado = (estado == DESLOCA) || buffer_cheio`.
- Reset:
  - Values: OCIOSO, `idx=0`, shift register and buffer cleared, `buffer_cheio=0`.
  - Reset mid-word discards both the word in flight and the buffered word. Bits already sent stay sent.
  - A transfer cannot occur on an edge where `reset=1`.
- Every output is a function of registered state plus `reset`. No combinational path runs from `dado` or `dado_valido` to any output.

## Timing
- Reset values the cycle after a reset edge: `saida=0`, `saida_valida=0`, `fim_palavra=0`, `ocupado=0`, `dado_pronto=1`.
- Latency: a word transferred at edge k presents bit 0 during the cycle after edge k. Bit LARGURA-1 is presented after edge k+LARGURA-1, with `fim_palavra=1` in that cycle.
- The downstream register captures bit i on edge k+1+i. The full word is in its A..D outputs after edge k+LARGURA.
- Throughput: one word per LARGURA cycles with no gap when upstream keeps `dado_valido` high.
- `dado_pronto` falls the cycle after a buffer write. It rises again the cycle after the last-bit edge that drains the buffer.
- Reset asserted for one edge is sufficient.

## Test plan
- **Single word:** reset, then `dado=4'b1011` valid for one cycle with `MSB_PRIMEIRO=1` -> `saida` = 1,0,1,1 on the next four cycles; `saida_valida` high for exactly those four; `fim_palavra` high on the 4th only; then OCIOSO with `ocupado=0`.
- **Back-to-back with backpressure:** present 4'b1011, 4'b0110, 4'b1111 with `dado_valido` held high ->
  - 12 contiguous valid bits: 1011 0110 1111, with no gap.
  - `dado_pronto` low whenever the buffer is full.
  - Each word is accepted exactly once.
- **Chained with the 4-bit shift register:** send 4'b1001, then 4'b0011 -> its outputs equal 1001 after the 4th bit edge and 0011 after the 8th.
- **Reset mid-word:** accept 4'b1100, buffer 4'b0101, assert `reset` after the 2nd bit ->
  - Next cycle: all outputs at reset values and `dado_pronto=1`.
  - 0101 is never emitted.
  - A new word 4'b0001 afterwards is serialized correctly.
- **LSB-first:** with `MSB_PRIMEIRO=0`, `dado=4'b1011` -> `saida` = 1,1,0,1.
- **Last-bit transfer with empty buffer:** a transfer lands on an edge where `fim_palavra=1` -> the next word's bit 0 appears in the following cycle and `saida_valida` stays continuously high.
